// File: rtl/dimple_pkg.sv
// Shared types and helpers for the coupling engine slice.
package dimple_pkg;

  // Evaluation sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  // Index width needed to address n items (never less than 1 bit).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Low bit of spin s inside a flattened vector of width-bit elements.
  function automatic int slice_lo(input int s, input int width);
    return s * width;
  endfunction

endpackage

// File: rtl/coupling_weight_mem.sv
// N x N signed weight store: synchronous write, combinational read,
// synchronous clear on reset.
module coupling_weight_mem
  import dimple_pkg::*;
#(
  parameter int SPINS    = 32,
  parameter int WEIGHT_W = 8,
  parameter int IDX_W    = idx_w(SPINS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    wr_row,
  input  logic [IDX_W-1:0]    wr_col,
  input  logic [WEIGHT_W-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_row,
  input  logic [IDX_W-1:0]    rd_col,
  output logic [WEIGHT_W-1:0] rd_data
);

  // One past the last legal index, one bit wider so SPINS itself fits.
  localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(SPINS);

  logic [WEIGHT_W-1:0] mem_q [SPINS][SPINS];
  logic                in_range;

  // Writes outside the matrix (SPINS not a power of two) are silently ignored.
  assign in_range = ({1'b0, wr_row} < LIMIT) && ({1'b0, wr_col} < LIMIT);

  // Weight array update: clear on reset, otherwise single-entry write.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is deliberately reset because J must read as zero
      // after reset; that rules out mapping it onto a RAM macro.
      for (int r = 0; r < SPINS; r++) begin
        for (int c = 0; c < SPINS; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we && in_range) begin
      mem_q[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_row][rd_col];

endmodule

// File: rtl/coupling_engine.sv
// Serial multiply-accumulate of J against the spin signs, one element per
// cycle, publishing the full coupling vector atomically when complete.
module coupling_engine
  import dimple_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SPINS    = 32,
  parameter int WEIGHT_W = 8,
  parameter int SHIFT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SPINS-1:0]         spin_sign,
  input  logic                     w_we,
  input  logic [idx_w(SPINS)-1:0]  w_row,
  input  logic [idx_w(SPINS)-1:0]  w_col,
  input  logic [WEIGHT_W-1:0]      w_data,
  output logic                     w_err,
  output logic                     busy,
  output logic                     done,
  output logic [SPINS*WIDTH-1:0]   coupling
);

  localparam int              IDX_W = idx_w(SPINS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SPINS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_e                   state_q, state_d;
  logic [SPINS-1:0]         sign_q;
  logic [IDX_W-1:0]         i_q, j_q;
  logic signed [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]         shadow_q [SPINS];
  logic [SPINS*WIDTH-1:0]   coupling_q;
  logic                     done_q;
  logic                     w_err_q;

  logic [WEIGHT_W-1:0]      w_cur;
  logic signed [WIDTH-1:0]  w_ext;
  logic signed [WIDTH-1:0]  term;
  logic signed [WIDTH-1:0]  sum;
  logic                     row_end;
  logic                     last_elem;
  logic                     mem_we;

  // Weights may only change while no evaluation is reading them.
  assign mem_we = w_we && (state_q == IDLE);

  coupling_weight_mem #(
    .SPINS    (SPINS),
    .WEIGHT_W (WEIGHT_W),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .wr_row  (w_row),
    .wr_col  (w_col),
    .wr_data (w_data),
    .rd_row  (i_q),
    .rd_col  (j_q),
    .rd_data (w_cur)
  );

  assign row_end   = (j_q == LAST);
  assign last_elem = row_end && (i_q == LAST);

  // Signed term for the current (i,j): diagonal is zero, negative spins flip J.
  always_comb begin
    w_ext = WIDTH'($signed(w_cur));
    term  = '0;
    if (i_q != j_q) begin
      term = sign_q[j_q] ? -w_ext : w_ext;
    end
    sum = acc_q + term;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: clocked state uses non-blocking (<=) so every flop samples the
      // pre-edge values; blocking here would create order-dependent races.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_elem) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, counters, row shadows and the published vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      coupling_q <= '0;
      done_q     <= 1'b0;
      w_err_q    <= 1'b0;
      for (int s = 0; s < SPINS; s++) begin
        shadow_q[s] <= '0;
      end
    end else begin
      done_q  <= 1'b0;
      w_err_q <= w_we && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sign_q <= spin_sign;
            i_q    <= '0;
            j_q    <= '0;
            acc_q  <= '0;
          end
        end
        RUN: begin
          if (row_end) begin
            shadow_q[i_q] <= sum >>> SHIFT;
            acc_q         <= '0;
            i_q           <= i_q + ONE;
            j_q           <= '0;
          end else begin
            acc_q <= sum;
            j_q   <= j_q + ONE;
          end
        end
        PUBLISH: begin
          for (int s = 0; s < SPINS; s++) begin
            coupling_q[slice_lo(s, WIDTH) +: WIDTH] <= shadow_q[s];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign w_err    = w_err_q;
  assign coupling = coupling_q;

endmodule
